// File: rtl/alu_pkg.sv
// Shared definitions for the iterative execution unit: ALUOp encodings,
// funct7 constants, the internal operation and FSM state enums, and the
// decode helpers used by alu_iter and alu_muldiv_iter.
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILLEGAL
    } alu_op_e;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    // funct3 table shared by R-type funct7=0 and I-type; alt selects SRA.
    function automatic alu_op_e base_op(logic [2:0] f3, logic alt);
        case (f3)
            3'b000:  base_op = OP_ADD;
            3'b001:  base_op = OP_SLL;
            3'b010:  base_op = OP_SLT;
            3'b011:  base_op = OP_SLTU;
            3'b100:  base_op = OP_XOR;
            3'b101:  base_op = alt ? OP_SRA : OP_SRL;
            3'b110:  base_op = OP_OR;
            default: base_op = OP_AND;
        endcase
    endfunction

    function automatic alu_op_e decode_op(logic [1:0] aluop, logic [2:0] f3,
                                          logic [6:0] f7, logic imm_sra);
        decode_op = OP_ILLEGAL;
        case (aluop)
            ALUOP_ADD:   decode_op = OP_ADD;
            ALUOP_SUB:   decode_op = OP_SUB;
            // I-type ignores funct7; imm bit 10 distinguishes srai from srli
            ALUOP_ITYPE: decode_op = base_op(f3, imm_sra);
            default: begin
                if (f7 == F7_BASE) begin
                    decode_op = base_op(f3, 1'b0);
                end else if (f7 == F7_ALT) begin
                    if (f3 == 3'b000)      decode_op = OP_SUB;
                    else if (f3 == 3'b101) decode_op = OP_SRA;
                end else if (f7 == F7_MULDIV) begin
                    case (f3)
                        3'b000:  decode_op = OP_MUL;
                        3'b001:  decode_op = OP_MULH;
                        3'b010:  decode_op = OP_MULHSU;
                        3'b011:  decode_op = OP_MULHU;
                        3'b100:  decode_op = OP_DIV;
                        3'b101:  decode_op = OP_DIVU;
                        3'b110:  decode_op = OP_REM;
                        default: decode_op = OP_REMU;
                    endcase
                end
            end
        endcase
    endfunction

    function automatic logic is_mul(alu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_div(alu_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Execute-stage handshake bundle for alu_iter.
//   Producer side: in_valid/in_ready, operands, imm, ALUSrc, ALUOp, funct3/7.
//   Consumer side: out_valid/out_ready, ALU_result, zero, illegal.
// master = pipeline (drives operations, takes results); slave = the unit.
interface alu_iter_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] read_data1;
    logic [XLEN-1:0] read_data2;
    logic [XLEN-1:0] imm;
    logic            ALUSrc;
    logic [1:0]      ALUOp;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ALU_result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, read_data1, read_data2, imm, ALUSrc, ALUOp, funct3,
               funct7, out_ready,
        input  in_ready, out_valid, ALU_result, zero, illegal
    );

    modport slave (
        input  in_valid, read_data1, read_data2, imm, ALUSrc, ALUOp, funct3,
               funct7, out_ready,
        output in_ready, out_valid, ALU_result, zero, illegal
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative multiply/divide engine.
//   clk, rst    : clock, async active-high reset (aborts a running op)
//   start_i     : latch op_i/a_i/b_i and begin XLEN iterations
//   op_i        : one of the mul/div operations
//   a_i, b_i    : raw operands
//   done_o      : high during the last iteration; result_o is valid then
//   result_o    : final (sign-corrected) result, combinational off done_o
module alu_muldiv_iter import alu_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  alu_op_e         op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);

    logic              run_q;
    logic [CW-1:0]     cnt_q;
    alu_op_e           op_q;
    logic [2*XLEN-1:0] acc_q, acc_d;   // mul: product; div: {remainder, quotient}
    logic [XLEN-1:0]   m_q;            // mul: multiplicand; div: divisor
    logic              negq_q, negr_q; // negate product/quotient, negate remainder

    logic            a_sgn, b_sgn;
    logic [XLEN-1:0] a_mag, b_mag;

    assign a_sgn = (op_i inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && a_i[XLEN-1];
    assign b_sgn = (op_i inside {OP_MULH, OP_DIV, OP_REM}) && b_i[XLEN-1];
    assign a_mag = a_sgn ? -a_i : a_i;
    assign b_mag = b_sgn ? -b_i : b_i;

    // Shift-add step: multiplier sits in the low half and is consumed LSB first.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nx, prod;
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
    assign mul_nx  = {mul_sum, acc_q[XLEN-1:1]};
    assign prod    = negq_q ? -mul_nx : mul_nx;

    // Restoring step: dividend shifts out of the low half, quotient bits in.
    logic [XLEN:0]   r_sh;
    logic            ge;
    logic [XLEN-1:0] rsub, r_nx, q_nx;
    assign r_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign ge   = r_sh >= {1'b0, m_q};
    assign rsub = r_sh[XLEN-1:0] - m_q;   // fits: r_sh - m < m when ge
    assign r_nx = ge ? rsub : r_sh[XLEN-1:0];
    assign q_nx = {acc_q[XLEN-2:0], ge};

    assign acc_d  = is_mul(op_q) ? mul_nx : {r_nx, q_nx};
    assign done_o = run_q && (cnt_q == '0);

    // Final iteration and sign fix-up happen in the same cycle.
    always_comb begin
        result_o = '0;
        case (op_q)
            OP_MUL:                     result_o = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_o = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            result_o = negq_q ? -q_nx : q_nx;
            default:                    result_o = negr_q ? -r_nx : r_nx;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            op_q   <= OP_ADD;
            acc_q  <= '0;
            m_q    <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else if (start_i) begin
            run_q  <= 1'b1;
            cnt_q  <= CW'(XLEN - 1);
            op_q   <= op_i;
            negq_q <= a_sgn ^ b_sgn;
            negr_q <= a_sgn;
            if (is_mul(op_i)) begin
                acc_q <= {{XLEN{1'b0}}, b_mag};
                m_q   <= a_mag;
            end else begin
                acc_q <= {{XLEN{1'b0}}, a_mag};
                m_q   <= b_mag;
            end
        end else if (run_q) begin
            acc_q <= acc_d;
            if (cnt_q == '0) run_q <= 1'b0;
            else             cnt_q <= cnt_q - 1'b1;
        end
    end
endmodule

// File: rtl/alu_iter.sv
// Multi-cycle RV32IM execution unit with valid/ready on both sides.
//   clk, rst : clock, async active-high reset
//   bus      : alu_iter_if.slave -- operation in (operands, imm, ALUSrc,
//              ALUOp, funct3/7, in_valid/in_ready) and registered result out
//              (ALU_result, zero, illegal, out_valid/out_ready)
// Base, illegal and divide special cases finish in one cycle; the remaining
// mul/div ops run XLEN iterations in alu_muldiv_iter.
module alu_iter import alu_pkg::*; #(
    parameter int XLEN = 32
) (
    input logic       clk,
    input logic       rst,
    alu_iter_if.slave bus
);
    localparam int SHW = $clog2(XLEN);
    // srai marker in the immediate; narrow datapaths fall back to the top bit
    localparam int SRAI_BIT = (XLEN > 10) ? 10 : XLEN - 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q;
    logic            out_valid_q, zero_q, illegal_q;
    logic [XLEN-1:0] result_q;

    logic [XLEN-1:0] op_a, op_b, quick_res, eng_res;
    logic [SHW-1:0]  shamt;
    alu_op_e         op;
    logic            accept, b_zero, div_ovf, special, start, eng_done;

    assign op_a  = bus.read_data1;
    assign op_b  = bus.ALUSrc ? bus.imm : bus.read_data2;
    assign shamt = op_b[SHW-1:0];
    assign op    = decode_op(bus.ALUOp, bus.funct3, bus.funct7, bus.imm[SRAI_BIT]);

    assign bus.in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Divide cases with a closed-form answer skip the engine.
    assign b_zero  = (op_b == '0);
    assign div_ovf = (op == OP_DIV || op == OP_REM) && (op_a == MIN_NEG) && (op_b == '1);
    assign special = is_div(op) && (b_zero || div_ovf);
    assign start   = accept && (is_mul(op) || is_div(op)) && !special;

    always_comb begin
        quick_res = '0;
        case (op)
            OP_ADD:          quick_res = op_a + op_b;
            OP_SUB:          quick_res = op_a - op_b;
            OP_SLL:          quick_res = op_a << shamt;
            OP_SLT:          quick_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU:         quick_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_XOR:          quick_res = op_a ^ op_b;
            OP_SRL:          quick_res = op_a >> shamt;
            OP_SRA:          quick_res = $unsigned($signed(op_a) >>> shamt);
            OP_OR:           quick_res = op_a | op_b;
            OP_AND:          quick_res = op_a & op_b;
            // overflow case: quotient = A, remainder = 0
            OP_DIV, OP_DIVU: quick_res = b_zero ? '1 : op_a;
            OP_REM, OP_REMU: quick_res = b_zero ? op_a : '0;
            default:         quick_res = '0;
        endcase
    end

    alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .op_i     (op),
        .a_i      (op_a),
        .b_i      (op_b),
        .done_o   (eng_done),
        .result_o (eng_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            illegal_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (start) begin
                            state_q     <= S_BUSY;
                            out_valid_q <= 1'b0;
                        end else begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= quick_res;
                            zero_q      <= (quick_res == '0);
                            illegal_q   <= (op == OP_ILLEGAL);
                        end
                    end else if ((state_q == S_DONE) && bus.out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (eng_done) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= eng_res;
                        zero_q      <= (eng_res == '0);
                        illegal_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.ALU_result = result_q;
    assign bus.zero       = zero_q;
    assign bus.illegal    = illegal_q;
endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter (XLEN = 32): directed vector table,
// randomized ops against an arithmetic reference model, and hand-written
// sequences for backpressure, back-to-back issue and reset during BUSY.
module tb_alu_iter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_iter_if #(.XLEN(32)) bus();
    alu_iter #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a, b, imm;
        logic        src;
        logic [31:0] exp_res;
        logic        exp_ill;
        int          exp_lat;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [1:0] aluop, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, b, imm, input logic src,
                       input logic [31:0] er, input logic ei, input int el);
        vec_t v;
        v.name = nm; v.aluop = aluop; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b;
        v.imm = imm; v.src = src; v.exp_res = er; v.exp_ill = ei; v.exp_lat = el;
        vecs.push_back(v);
    endtask

    // Reference model straight from the RV32IM rules using 64-bit arithmetic.
    task automatic model(input logic [1:0] aluop, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, b_reg, imm, input logic src,
                         output logic [31:0] res, output logic ill, output int lat);
        logic [31:0] b;
        logic signed [63:0] sa, sb, p, q, r;
        int sh;
        b = src ? imm : b_reg;
        sh = int'(b[4:0]);
        res = 32'h0; ill = 1'b0; lat = 1;
        if (aluop == 2'b00) res = a + b;
        else if (aluop == 2'b01) res = a - b;
        else if (aluop == 2'b11 || f7 == 7'h00) begin
            case (f3)
                3'd0: res = a + b;
                3'd1: res = a << sh;
                3'd2: res = {31'b0, $signed(a) < $signed(b)};
                3'd3: res = {31'b0, a < b};
                3'd4: res = a ^ b;
                3'd5: if (aluop == 2'b11 && imm[10]) res = $signed(a) >>> sh;
                      else res = a >> sh;
                3'd6: res = a | b;
                default: res = a & b;
            endcase
        end else if (f7 == 7'h20) begin
            if (f3 == 3'd0) res = a - b;
            else if (f3 == 3'd5) res = $signed(a) >>> sh;
            else ill = 1'b1;
        end else if (f7 == 7'h01) begin
            sa = (f3 inside {3'd1, 3'd2, 3'd4, 3'd6}) ? {{32{a[31]}}, a} : {32'b0, a};
            sb = (f3 inside {3'd1, 3'd4, 3'd6}) ? {{32{b[31]}}, b} : {32'b0, b};
            if (f3 < 3'd4) begin
                p = sa * sb;
                res = (f3 == 3'd0) ? p[31:0] : p[63:32];
                lat = 33;
            end else if (b == 32'h0) begin
                res = (f3 < 3'd6) ? 32'hFFFFFFFF : a;
            end else begin
                q = sa / sb;
                r = sa % sb;
                res = (f3 < 3'd6) ? q[31:0] : r[31:0];
                // signed -2^31 / -1 has a closed-form answer: single cycle
                lat = (f3 inside {3'd4, 3'd6} && a == 32'h80000000 && b == 32'hFFFFFFFF) ? 1 : 33;
            end
        end else ill = 1'b1;
    endtask

    task automatic set_op(input logic [1:0] aluop, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, b, imm, input logic src);
        bus.ALUOp = aluop; bus.funct3 = f3; bus.funct7 = f7;
        bus.read_data1 = a; bus.read_data2 = b; bus.imm = imm; bus.ALUSrc = src;
    endtask

    // Issue one op from IDLE, wait for the result (bounded), then consume it.
    task automatic run_op(input logic [1:0] aluop, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, b, imm, input logic src,
                          output logic [31:0] res, output logic ill, output logic zr,
                          output int lat, output logic rdy_bad);
        int guard;
        @(negedge clk);
        set_op(aluop, f3, f7, a, b, imm, src);
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin @(negedge clk); guard++; end
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1; rdy_bad = 1'b0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) rdy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        res = bus.ALU_result; ill = bus.illegal; zr = bus.zero;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(7))
            0: return 32'h0;
            1: return 32'($urandom_range(20));
            2: return -32'($urandom_range(20));
            3: return 32'h80000000;
            4: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res, er, a, b, imm;
        logic ill, zr, rb, ei, src, seen;
        int lat, el, guard, sel;
        logic [1:0] aluop;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] b2b_exp[4];

        add("add",      2'b10, 3'd0, 7'h00, 32'd7,        32'd5,        32'd0,     1'b0, 32'd12,       1'b0, 1);
        add("sub zero", 2'b10, 3'd0, 7'h20, 32'd5,        32'd5,        32'd0,     1'b0, 32'd0,        1'b0, 1);
        add("sra",      2'b10, 3'd5, 7'h20, 32'h80000000, 32'd4,        32'd0,     1'b0, 32'hF8000000, 1'b0, 1);
        add("srai",     2'b11, 3'd5, 7'h20, 32'h80000000, 32'd0,        32'h404,   1'b1, 32'hF8000000, 1'b0, 1);
        add("sltu",     2'b10, 3'd3, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd0,     1'b0, 32'd1,        1'b0, 1);
        add("slt",      2'b10, 3'd2, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd0,     1'b0, 32'd0,        1'b0, 1);
        add("mulh",     2'b10, 3'd1, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,     1'b0, 32'd0,        1'b0, 33);
        add("mulhu",    2'b10, 3'd3, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,     1'b0, 32'hFFFFFFFE, 1'b0, 33);
        add("mulhsu",   2'b10, 3'd2, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,     1'b0, 32'hFFFFFFFF, 1'b0, 33);
        add("mul",      2'b10, 3'd0, 7'h01, 32'd3,        32'hFFFFFFFC, 32'd0,     1'b0, 32'hFFFFFFF4, 1'b0, 33);
        add("div by0",  2'b10, 3'd4, 7'h01, 32'd7,        32'd0,        32'd0,     1'b0, 32'hFFFFFFFF, 1'b0, 1);
        add("rem by0",  2'b10, 3'd6, 7'h01, 32'd7,        32'd0,        32'd0,     1'b0, 32'd7,        1'b0, 1);
        add("div ovf",  2'b10, 3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0,     1'b0, 32'h80000000, 1'b0, 1);
        add("rem ovf",  2'b10, 3'd6, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0,     1'b0, 32'd0,        1'b0, 1);
        add("div neg",  2'b10, 3'd4, 7'h01, 32'hFFFFFFF9, 32'd2,        32'd0,     1'b0, 32'hFFFFFFFD, 1'b0, 33);
        add("rem neg",  2'b10, 3'd6, 7'h01, 32'hFFFFFFF9, 32'd2,        32'd0,     1'b0, 32'hFFFFFFFF, 1'b0, 33);
        add("divu",     2'b10, 3'd5, 7'h01, 32'd100,      32'd7,        32'd0,     1'b0, 32'd14,       1'b0, 33);
        add("illegal",  2'b10, 3'd0, 7'h02, 32'd9,        32'd3,        32'd0,     1'b0, 32'd0,        1'b1, 1);

        // Reset state
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        set_op(2'b00, 3'd0, 7'h00, 32'd0, 32'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset ALU_result", bus.ALU_result, 32'd0);
        check("reset zero", 32'(bus.zero), 32'd1);
        check("reset illegal", 32'(bus.illegal), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].aluop, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, vecs[i].imm,
                   vecs[i].src, res, ill, zr, lat, rb);
            check({vecs[i].name, " result"}, res, vecs[i].exp_res);
            check({vecs[i].name, " illegal"}, 32'(ill), 32'(vecs[i].exp_ill));
            check({vecs[i].name, " zero"}, 32'(zr), 32'(vecs[i].exp_res == 32'h0));
            check({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            check({vecs[i].name, " in_ready low while busy"}, 32'(rb), 32'd0);
        end

        // Randomized ops against the model
        for (int i = 0; i < 300; i++) begin
            aluop = 2'($urandom_range(3));
            f3    = 3'($urandom_range(7));
            sel   = $urandom_range(9);
            f7    = (sel < 3) ? 7'h00 : (sel < 5) ? 7'h20 : (sel < 8) ? 7'h01 : 7'($urandom);
            a = pick(); b = pick(); imm = pick();
            src = (aluop == 2'b11) ? 1'b1 : 1'($urandom_range(1));
            model(aluop, f3, f7, a, b, imm, src, er, ei, el);
            run_op(aluop, f3, f7, a, b, imm, src, res, ill, zr, lat, rb);
            check($sformatf("rand%0d op%0d f3=%0d f7=%02h a=%08h b=%08h result", i, aluop, f3, f7, a, b), res, er);
            check($sformatf("rand%0d illegal", i), 32'(ill), 32'(ei));
            check($sformatf("rand%0d latency", i), 32'(lat), 32'(el));
        end

        // Backpressure: hold the mul result for 5 cycles with a new op waiting
        @(negedge clk);
        set_op(2'b10, 3'd0, 7'h01, 32'd3, 32'hFFFFFFFC, 32'd0, 1'b0);
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < 100) begin @(negedge clk); guard++; end
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                set_op(2'b10, 3'd0, 7'h00, 32'd1, 32'd1, 32'd0, 1'b0);
                bus.in_valid = 1'b1;
            end
            check($sformatf("bp hold result c%0d", c), bus.ALU_result, 32'hFFFFFFF4);
            check($sformatf("bp hold out_valid c%0d", c), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp in_ready c%0d", c), 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp accept in DONE out_valid", 32'(bus.out_valid), 32'd1);
        check("bp accept in DONE result", bus.ALU_result, 32'd2);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp drain to IDLE", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // Back-to-back base ops, one result per cycle
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                check($sformatf("b2b%0d out_valid", k - 1), 32'(bus.out_valid), 32'd1);
                check($sformatf("b2b%0d result", k - 1), bus.ALU_result, b2b_exp[k-1]);
            end
            if (k < 4) begin
                a = $urandom; b = $urandom;
                f3 = (k % 2 == 0) ? 3'd0 : 3'd4;
                set_op(2'b10, f3, 7'h00, a, b, 32'd0, 1'b0);
                model(2'b10, f3, 7'h00, a, b, 32'd0, 1'b0, b2b_exp[k], ei, el);
                bus.in_valid = 1'b1;
            end else bus.in_valid = 1'b0;
            @(negedge clk);
        end
        check("b2b drain out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // Reset at BUSY cycle 10
        @(negedge clk);
        set_op(2'b10, 3'd4, 7'h01, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("busy before reset in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post-abort in_ready", 32'(bus.in_ready), 32'd1);
        check("post-abort ALU_result", bus.ALU_result, 32'd0);
        check("post-abort zero", 32'(bus.zero), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("post-abort no result", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised multi-cycle execution unit, the successor to the single-cycle ALU in the CPU datapath. It keeps the same operand-select and ALUOp/funct decode front end, extends the base operation set to the full RV32I ALU, and adds the RV32M multiply/divide group through an iterative radix-2 engine. A valid/ready handshake on both sides lets the pipeline stall on long operations. It sits in the execute stage, between register read / immediate generation and the memory/writeback stage.

## Interface
- XLEN, 32: datapath width; must be ≥ 8 and even.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts operation this cycle
- read_data1  in  XLEN  operand A
- read_data2  in  XLEN  operand B (register)
- imm  in  XLEN  sign-extended immediate
- ALUSrc  in  1  1: operand B = imm
- ALUOp  in  2  00 add, 01 sub, 10 R-type decode, 11 I-type decode
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- ALU_result  out  XLEN  registered result
- zero  out  1  ALU_result == 0, registered with ALU_result
- illegal  out  1  registered with result; decode hit an unsupported funct7/funct3 (result 0)

## Operation
- Decode:
  - R-type, funct7 = 0000000: add, sll, slt, sltu, xor, srl, or, and.
  - R-type, funct7 = 0100000: sub (f3 = 000), sra (f3 = 101).
  - R-type, funct7 = 0000001: mul, mulh, mulhsu, mulhu, div, divu, rem, remu (f3 = 000..111).
  - I-type: same as R-type funct7 = 0 with operand B = imm. f3 = 101 with imm[10] = 1 is srai. There is no I-type sub.
  - Any other combination sets illegal and gives result 0.
- Shifts use operand B[log2(XLEN)-1:0] only.
- States: IDLE, BUSY, DONE.
  - IDLE: in_ready = 1. On accept:
    - base op, illegal op, or div special case: compute, register the result, go to DONE.
    - mul or div group: latch operands, go to BUSY.
  - BUSY: in_ready = 0. The iteration counter runs from XLEN-1 down to 0. Counter 0 plus finalisation moves to DONE.
  - DONE: out_valid = 1 and the result is held stable.
    - out_ready = 1: if in_valid is also 1, accept the new op in the same cycle (as IDLE would); otherwise go to IDLE.
    - in_ready = out_ready in DONE.
- Multiply: shift-add on operand magnitudes into a 2·XLEN product, then a conditional negate in the final cycle. Sign handling per op:
  - mulh: both operands signed.
  - mulhsu: A signed, B unsigned.
  - mulhu: both unsigned.
  - mul returns the low XLEN bits; the others return the high XLEN bits.
- Divide: restoring division on magnitudes, with sign fix-up in the final cycle. Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
- Special cases complete in 1 cycle and never enter BUSY:
  - divisor 0: quotient = all ones, remainder = A.
  - signed A = −2^(XLEN−1) with B = −1: quotient = A, remainder = 0.
- Arithmetic wraps modulo 2^XLEN. Overflow is not flagged.

## Timing
- Reset: state IDLE, out_valid 0, ALU_result 0, zero 1, illegal 0, counter 0.
- Base, illegal and special-case ops: accepted at edge k, out_valid high after edge k+1.
- Mul/div group: accepted at edge k, out_valid high after edge k+XLEN+1 (33 cycles at XLEN = 32).
- Back-to-back base ops with out_ready held at 1 give one result per cycle.
- ALU_result, zero and illegal change only on a transition into DONE.
- Reset asserted mid-BUSY aborts the operation immediately and produces no result after reset is released.
- in_valid while BUSY is ignored (in_ready = 0); the producer holds its operands.

## Structure
- Package alu_pkg holds:
  - ALUOp encodings.
  - The internal operation enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, ILLEGAL.
  - The state enum.
  - The funct7 constants.
- One sub-module, alu_muldiv_iter:
  - Holds the iterative engine: operand registers, accumulator, counter and final sign fix-up.
  - Has a start/done interface to the top-level FSM.
  - Is parametrised by XLEN.

## Test plan
- Reset and base ops:
  - After reset, check out_valid = 0, ALU_result = 0, zero = 1.
  - ALUOp = 10, f3 = 000, f7 = 0, A = 7, B = 5 → ALU_result = 12 one cycle after accept.
  - Same with f7 = 0100000, A = 5, B = 5 → ALU_result = 0, zero = 1.
- Shifts and compares:
  - sra A = 0x80000000, B = 4 → 0xF8000000.
  - srai with imm = 0x404 → same 0xF8000000.
  - sltu A = 1, B = 0xFFFFFFFF → 1.
  - slt on the same operands → 0.
- Multiply:
  - mulh A = 0xFFFFFFFF, B = 0xFFFFFFFF → 0.
  - mulhu on the same operands → 0xFFFFFFFE.
  - mul A = 3, B = −4 → 0xFFFFFFF4.
  - Each gives out_valid exactly 33 cycles after accept, with in_ready = 0 throughout.
- Divide special cases:
  - div A = 7, B = 0 → 0xFFFFFFFF.
  - rem A = 7, B = 0 → 7.
  - div A = 0x80000000, B = −1 → 0x80000000.
  - rem A = 0x80000000, B = −1 → 0.
  - All four complete in 1 cycle.
  - div A = −7, B = 2 → −3; rem → −1, after 33 cycles.
- Backpressure and reset:
  - Hold out_ready = 0 for 5 cycles in DONE → result stable and in_ready = 0.
  - Assert rst at BUSY cycle 10 → out_valid stays 0 and state is IDLE after release.
  - Send f7 = 0000010 → illegal = 1, result 0.
